pmu_axil_regif: RTL and testbench

AXI4-Lite slave that sits between the NoC AXI-lite bridge and the PMU counter bank, on the NoC clock. It converts single-beat 64-bit AXI-lite reads and writes into the counter bank's level-based four-phase enable/valid handshake. The counter bank runs on a separate counter clock, so the returning valid levels are synchronised here. Serialises transactions, arbitrates fairly between reads and writes, and converts a stalled counter side into an SLVERR by timeout.

---
 rtl/pmu_regif_pkg.sv | 20 ++
 rtl/synchronizer_2_stage.sv | 22 ++
 rtl/pmu_axil_regif.sv | 204 ++++++++++++++++++++
 tb/tb_pmu_axil_regif.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_regif_pkg.sv
// Shared types and constants for the PMU AXI-lite register interface.
package pmu_regif_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_REL,
      WR_RESP,
      RD_REQ,
      RD_REL,
      RD_RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Counter registers are 64-bit; accesses must be 8-byte aligned.
   localparam int unsigned ALIGN_BITS = 3;

endpackage

// File: rtl/synchronizer_2_stage.sv
// Two-flop level synchroniser into the clk domain.
module synchronizer_2_stage (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic meta;

   // Shift the asynchronous level through two flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/pmu_axil_regif.sv
// AXI4-Lite slave bridging single-beat accesses onto the PMU counter bank's
// four-phase enable/valid handshake, with read/write arbitration and timeout.
module pmu_axil_regif
   import pmu_regif_pkg::*;
#(
   parameter int unsigned DATA_WIDTH            = 64,
   parameter int unsigned ADDRESS_WIDTH         = 64,
   parameter int unsigned COUNTER_ADDRESS_WIDTH = 16,
   parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
   input  logic                             noc_clk,
   input  logic                             rst,
   input  logic [ADDRESS_WIDTH-1:0]         s_axi_awaddr,
   input  logic                             s_axi_awvalid,
   output logic                             s_axi_awready,
   input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
   input  logic                             s_axi_wvalid,
   output logic                             s_axi_wready,
   output logic [1:0]                       s_axi_bresp,
   output logic                             s_axi_bvalid,
   input  logic                             s_axi_bready,
   input  logic [ADDRESS_WIDTH-1:0]         s_axi_araddr,
   input  logic                             s_axi_arvalid,
   output logic                             s_axi_arready,
   output logic [DATA_WIDTH-1:0]            s_axi_rdata,
   output logic [1:0]                       s_axi_rresp,
   output logic                             s_axi_rvalid,
   input  logic                             s_axi_rready,
   output logic                             counter_read_enable,
   input  logic                             counter_read_valid,
   output logic [COUNTER_ADDRESS_WIDTH-1:0] counter_read_address,
   input  logic [DATA_WIDTH-1:0]            counter_read_data,
   output logic                             counter_write_enable,
   input  logic                             counter_write_valid,
   output logic [COUNTER_ADDRESS_WIDTH-1:0] counter_write_address,
   output logic [DATA_WIDTH-1:0]            counter_write_data
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e                           state, state_nxt;
   logic                             aw_full, w_full, ar_full, ready_en;
   logic [COUNTER_ADDRESS_WIDTH-1:0] aw_addr_q, ar_addr_q;
   logic [DATA_WIDTH-1:0]            w_data_q;
   logic [DATA_WIDTH/8-1:0]          w_strb_q;
   logic                             last_wr;
   logic [TW-1:0]                    tcnt;
   logic                             rv_s, wv_s;
   logic                             serve_wr, serve_rd, wr_legal, rd_legal, timeout;

   // Address bits above the counter address alias onto the same registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr[ADDRESS_WIDTH-1:COUNTER_ADDRESS_WIDTH],
                               s_axi_araddr[ADDRESS_WIDTH-1:COUNTER_ADDRESS_WIDTH]};

   synchronizer_2_stage u_sync_rv (
      .clk  (noc_clk),
      .rst  (rst),
      .din  (counter_read_valid),
      .dout (rv_s)
   );

   synchronizer_2_stage u_sync_wv (
      .clk  (noc_clk),
      .rst  (rst),
      .din  (counter_write_valid),
      .dout (wv_s)
   );

   // Arbitration and legality decode for the pending transactions.
   always_comb begin
      serve_wr = 1'b0;
      serve_rd = 1'b0;
      if (aw_full && w_full && ar_full) begin
         serve_rd = last_wr;
         serve_wr = !last_wr;
      end else begin
         serve_wr = aw_full && w_full;
         serve_rd = ar_full;
      end
      wr_legal = (&w_strb_q) && (aw_addr_q[ALIGN_BITS-1:0] == '0);
      rd_legal = (ar_addr_q[ALIGN_BITS-1:0] == '0);
      timeout  = (tcnt == T_LAST);
   end

   // State register.
   always_ff @(posedge noc_clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (serve_wr)      state_nxt = wr_legal ? WR_REQ : WR_RESP;
            else if (serve_rd) state_nxt = rd_legal ? RD_REQ : RD_RESP;
         end
         WR_REQ:  if (wv_s || timeout) state_nxt = WR_REL;
         WR_REL:  if (!wv_s)           state_nxt = WR_RESP;
         WR_RESP: if (s_axi_bready)    state_nxt = IDLE;
         RD_REQ:  if (rv_s || timeout) state_nxt = RD_REL;
         RD_REL:  if (!rv_s)           state_nxt = RD_RESP;
         RD_RESP: if (s_axi_rready)    state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // Handshake and enable outputs decoded from state and capture flags.
   always_comb begin
      s_axi_awready        = ready_en && !aw_full;
      s_axi_wready         = ready_en && !w_full;
      s_axi_arready        = ready_en && !ar_full;
      s_axi_bvalid         = (state == WR_RESP);
      s_axi_rvalid         = (state == RD_RESP);
      counter_write_enable = (state == WR_REQ);
      counter_read_enable  = (state == RD_REQ);
   end

   // Capture registers, arbitration history, timeout counter and responses.
   always_ff @(posedge noc_clk or negedge rst) begin
      if (!rst) begin
         ready_en              <= 1'b0;
         aw_full               <= 1'b0;
         w_full                <= 1'b0;
         ar_full               <= 1'b0;
         aw_addr_q             <= '0;
         ar_addr_q             <= '0;
         w_data_q              <= '0;
         w_strb_q              <= '0;
         last_wr               <= 1'b1;
         tcnt                  <= '0;
         s_axi_bresp           <= RESP_OKAY;
         s_axi_rresp           <= RESP_OKAY;
         s_axi_rdata           <= '0;
         counter_write_address <= '0;
         counter_write_data    <= '0;
         counter_read_address  <= '0;
      end else begin
         ready_en <= 1'b1;
         if (s_axi_awvalid && s_axi_awready) begin
            aw_full   <= 1'b1;
            aw_addr_q <= s_axi_awaddr[COUNTER_ADDRESS_WIDTH-1:0];
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_full   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (s_axi_arvalid && s_axi_arready) begin
            ar_full   <= 1'b1;
            ar_addr_q <= s_axi_araddr[COUNTER_ADDRESS_WIDTH-1:0];
         end
         if (state == WR_RESP && s_axi_bready) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end
         if (state == RD_RESP && s_axi_rready) ar_full <= 1'b0;

         if (state != WR_REQ && state != RD_REQ) tcnt <= '0;
         else if (!timeout)                      tcnt <= tcnt + TW'(1);

         case (state)
            IDLE: begin
               if (serve_wr) begin
                  last_wr <= 1'b1;
                  if (wr_legal) begin
                     counter_write_address <= aw_addr_q;
                     counter_write_data    <= w_data_q;
                  end else begin
                     s_axi_bresp <= RESP_SLVERR;
                  end
               end else if (serve_rd) begin
                  last_wr <= 1'b0;
                  if (rd_legal) begin
                     counter_read_address <= ar_addr_q;
                  end else begin
                     s_axi_rdata <= '0;
                     s_axi_rresp <= RESP_SLVERR;
                  end
               end
            end
            WR_REQ: begin
               if (wv_s)         s_axi_bresp <= RESP_OKAY;
               else if (timeout) s_axi_bresp <= RESP_SLVERR;
            end
            RD_REQ: begin
               if (rv_s) begin
                  s_axi_rdata <= counter_read_data;
                  s_axi_rresp <= RESP_OKAY;
               end else if (timeout) begin
                  s_axi_rdata <= '1;
                  s_axi_rresp <= RESP_SLVERR;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pmu_axil_regif.sv
// Directed self-checking bench for pmu_axil_regif with a behavioural counter bank.
module tb_pmu_axil_regif;

   logic        noc_clk = 1'b0;
   logic        counter_clk = 1'b0;
   logic        rst;
   logic [63:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [63:0] s_axi_wdata;
   logic [7:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [63:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        counter_read_enable;
   logic        counter_read_valid;
   logic [15:0] counter_read_address;
   logic [63:0] counter_read_data;
   logic        counter_write_enable;
   logic        counter_write_valid;
   logic [15:0] counter_write_address;
   logic [63:0] counter_write_data;

   always #5 noc_clk = ~noc_clk;
   always #7 counter_clk = ~counter_clk;

   pmu_axil_regif #(
      .DATA_WIDTH            (64),
      .ADDRESS_WIDTH         (64),
      .COUNTER_ADDRESS_WIDTH (16),
      .TIMEOUT_CYCLES        (1024)
   ) dut (
      .noc_clk               (noc_clk),
      .rst                   (rst),
      .s_axi_awaddr          (s_axi_awaddr),
      .s_axi_awvalid         (s_axi_awvalid),
      .s_axi_awready         (s_axi_awready),
      .s_axi_wdata           (s_axi_wdata),
      .s_axi_wstrb           (s_axi_wstrb),
      .s_axi_wvalid          (s_axi_wvalid),
      .s_axi_wready          (s_axi_wready),
      .s_axi_bresp           (s_axi_bresp),
      .s_axi_bvalid          (s_axi_bvalid),
      .s_axi_bready          (s_axi_bready),
      .s_axi_araddr          (s_axi_araddr),
      .s_axi_arvalid         (s_axi_arvalid),
      .s_axi_arready         (s_axi_arready),
      .s_axi_rdata           (s_axi_rdata),
      .s_axi_rresp           (s_axi_rresp),
      .s_axi_rvalid          (s_axi_rvalid),
      .s_axi_rready          (s_axi_rready),
      .counter_read_enable   (counter_read_enable),
      .counter_read_valid    (counter_read_valid),
      .counter_read_address  (counter_read_address),
      .counter_read_data     (counter_read_data),
      .counter_write_enable  (counter_write_enable),
      .counter_write_valid   (counter_write_valid),
      .counter_write_address (counter_write_address),
      .counter_write_data    (counter_write_data)
   );

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Behavioural counter bank on its own clock.
   logic [63:0] mem [logic [15:0]];
   bit          no_ack = 1'b0;
   int unsigned ack_delay = 5;

   initial begin
      int unsigned n;
      counter_read_valid  = 1'b0;
      counter_write_valid = 1'b0;
      counter_read_data   = '0;
      forever begin
         @(posedge counter_clk);
         if (!no_ack && counter_write_enable) begin
            repeat (ack_delay) @(posedge counter_clk);
            mem[counter_write_address] = counter_write_data;
            counter_write_valid = 1'b1;
            n = 0;
            while (counter_write_enable && n < 5000) begin @(posedge counter_clk); n++; end
            counter_write_valid = 1'b0;
         end else if (!no_ack && counter_read_enable) begin
            repeat (ack_delay) @(posedge counter_clk);
            counter_read_data = mem.exists(counter_read_address) ? mem[counter_read_address] : '1;
            counter_read_valid = 1'b1;
            n = 0;
            while (counter_read_enable && n < 5000) begin @(posedge counter_clk); n++; end
            counter_read_valid = 1'b0;
         end
      end
   end

   // Monitors for write-enable pulses, held address/data and overlapping enables.
   logic        we_d = 1'b0;
   int unsigned wr_pulses = 0;
   logic [15:0] last_wa = '0;
   logic [63:0] last_wd = '0;
   bit          both_high = 1'b0;
   bit          wr_unstable = 1'b0;

   always @(posedge noc_clk) begin
      we_d <= counter_write_enable;
      if (counter_write_enable && !we_d) begin
         wr_pulses <= wr_pulses + 1;
         last_wa   <= counter_write_address;
         last_wd   <= counter_write_data;
      end
      if (counter_write_enable && we_d &&
          (counter_write_address != last_wa || counter_write_data != last_wd))
         wr_unstable <= 1'b1;
      if (counter_write_enable && counter_read_enable) both_high <= 1'b1;
   end

   task automatic axi_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, input int unsigned w_lead);
      bit aw_d, w_d, hs_aw, hs_w;
      int unsigned n;
      aw_d = 0; w_d = 0; n = 0;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_wvalid = 1'b1;
      s_axi_awvalid = (w_lead == 0);
      while (!(aw_d && w_d) && n < 200) begin
         hs_aw = s_axi_awvalid && s_axi_awready;
         hs_w  = s_axi_wvalid && s_axi_wready;
         @(posedge noc_clk); #1; n++;
         if (hs_aw) begin aw_d = 1; s_axi_awvalid = 1'b0; end
         if (hs_w)  begin w_d = 1;  s_axi_wvalid = 1'b0; end
         if (!aw_d && !s_axi_awvalid && n >= w_lead) s_axi_awvalid = 1'b1;
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("aw_w_accept", 64'(aw_d && w_d), 64'd1);
   endtask

   task automatic axi_read(input logic [63:0] a);
      bit ar_d, hs;
      int unsigned n;
      ar_d = 0; n = 0;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      while (!ar_d && n < 200) begin
         hs = s_axi_arready;
         @(posedge noc_clk); #1; n++;
         if (hs) begin ar_d = 1; s_axi_arvalid = 1'b0; end
      end
      s_axi_arvalid = 1'b0;
      check("ar_accept", 64'(ar_d), 64'd1);
   endtask

   task automatic issue_all(input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] ra);
      bit aw_d, w_d, ar_d, hs_aw, hs_w, hs_ar;
      int unsigned n;
      aw_d = 0; w_d = 0; ar_d = 0; n = 0;
      s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = 8'hFF; s_axi_araddr = ra;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      while (!(aw_d && w_d && ar_d) && n < 200) begin
         hs_aw = s_axi_awvalid && s_axi_awready;
         hs_w  = s_axi_wvalid && s_axi_wready;
         hs_ar = s_axi_arvalid && s_axi_arready;
         @(posedge noc_clk); #1; n++;
         if (hs_aw) begin aw_d = 1; s_axi_awvalid = 1'b0; end
         if (hs_w)  begin w_d = 1;  s_axi_wvalid = 1'b0; end
         if (hs_ar) begin ar_d = 1; s_axi_arvalid = 1'b0; end
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      check("tie_accept", 64'(aw_d && w_d && ar_d), 64'd1);
   endtask

   task automatic get_b(input logic [1:0] exp, input int unsigned hold, input string tag);
      int unsigned n;
      logic [1:0] r0;
      bit bad;
      n = 0; bad = 0;
      s_axi_bready = 1'b0;
      while (!s_axi_bvalid && n < 4000) begin @(posedge noc_clk); #1; n++; end
      check({tag, "_bvalid"}, 64'(s_axi_bvalid), 64'd1);
      if (s_axi_bvalid) begin
         r0 = s_axi_bresp;
         repeat (hold) begin
            @(posedge noc_clk); #1;
            if (!s_axi_bvalid || s_axi_bresp !== r0) bad = 1;
         end
         if (hold > 0) check({tag, "_stable"}, 64'(bad), 64'd0);
         check({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp));
         s_axi_bready = 1'b1;
         @(posedge noc_clk); #1;
         s_axi_bready = 1'b0;
         check({tag, "_bvalid_drop"}, 64'(s_axi_bvalid), 64'd0);
      end
   endtask

   task automatic get_r(input logic [63:0] exp_d, input logic [1:0] exp_r,
                        input int unsigned hold, input string tag);
      int unsigned n;
      logic [63:0] d0;
      logic [1:0] r0;
      bit bad;
      n = 0; bad = 0;
      s_axi_rready = 1'b0;
      while (!s_axi_rvalid && n < 4000) begin @(posedge noc_clk); #1; n++; end
      check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
      if (s_axi_rvalid) begin
         d0 = s_axi_rdata; r0 = s_axi_rresp;
         repeat (hold) begin
            @(posedge noc_clk); #1;
            if (!s_axi_rvalid || s_axi_rdata !== d0 || s_axi_rresp !== r0) bad = 1;
         end
         if (hold > 0) check({tag, "_stable"}, 64'(bad), 64'd0);
         check({tag, "_rdata"}, s_axi_rdata, exp_d);
         check({tag, "_rresp"}, 64'(s_axi_rresp), 64'(exp_r));
         s_axi_rready = 1'b1;
         @(posedge noc_clk); #1;
         s_axi_rready = 1'b0;
         check({tag, "_rvalid_drop"}, 64'(s_axi_rvalid), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned p, n;
      rst = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;

      // Reset state.
      repeat (3) @(posedge noc_clk);
      #1;
      check("rst_awready", 64'(s_axi_awready), 64'd0);
      check("rst_arready", 64'(s_axi_arready), 64'd0);
      check("rst_wready", 64'(s_axi_wready), 64'd0);
      check("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
      check("rst_enables", 64'({counter_read_enable, counter_write_enable}), 64'd0);
      check("rst_rdata", s_axi_rdata, 64'd0);
      check("rst_cw_addr", 64'(counter_write_address), 64'd0);
      rst = 1'b1;
      @(posedge noc_clk); #1;
      check("post_rst_awready", 64'(s_axi_awready), 64'd1);

      // Write then read back.
      axi_write(64'h000, 64'h1, 8'hFF, 0);
      get_b(OKAY, 0, "wr0");
      axi_write(64'h008, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0);
      get_b(OKAY, 0, "wr8");
      axi_read(64'h008);
      get_r(64'hDEAD_BEEF_0000_0001, OKAY, 0, "rd8");
      check("wr_pulses_2", 64'(wr_pulses), 64'd2);

      // W ahead of AW, then AW and W together.
      p = wr_pulses;
      axi_write(64'h018, 64'h1122_3344_5566_7788, 8'hFF, 3);
      get_b(OKAY, 0, "wlead");
      check("wlead_pulse", 64'(wr_pulses), 64'(p + 1));
      check("wlead_addr", 64'(last_wa), 64'h018);
      check("wlead_data", last_wd, 64'h1122_3344_5566_7788);
      axi_write(64'h020, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 0);
      get_b(OKAY, 0, "wsame");
      check("wsame_pulse", 64'(wr_pulses), 64'(p + 2));
      check("wsame_addr", 64'(last_wa), 64'h020);
      check("wsame_data", last_wd, 64'hA5A5_A5A5_5A5A_5A5A);

      // Tie after a write was served last: read first.
      issue_all(64'h028, 64'h0000_0000_CAFE_0028, 64'h000);
      repeat (2) @(posedge noc_clk);
      #1;
      check("tie1_rd_en", 64'(counter_read_enable), 64'd1);
      check("tie1_wr_en", 64'(counter_write_enable), 64'd0);
      get_r(64'h1, OKAY, 0, "tie1_rd");
      get_b(OKAY, 0, "tie1_wr");
      // Plain read so a read was served last, then tie again: write first.
      axi_read(64'h020);
      get_r(64'hA5A5_A5A5_5A5A_5A5A, OKAY, 0, "rd20");
      issue_all(64'h030, 64'h0000_0000_BEEF_0030, 64'h028);
      repeat (2) @(posedge noc_clk);
      #1;
      check("tie2_wr_en", 64'(counter_write_enable), 64'd1);
      check("tie2_rd_en", 64'(counter_read_enable), 64'd0);
      get_b(OKAY, 0, "tie2_wr");
      get_r(64'h0000_0000_CAFE_0028, OKAY, 0, "tie2_rd");
      check("both_enables_never", 64'(both_high), 64'd0);
      check("wr_addr_data_held", 64'(wr_unstable), 64'd0);

      // Illegal requests.
      p = wr_pulses;
      axi_write(64'h038, 64'h5, 8'h0F, 0);
      get_b(SLVERR, 0, "bad_strb");
      check("bad_strb_no_pulse", 64'(wr_pulses), 64'(p));
      axi_read(64'h004);
      get_r(64'h0, SLVERR, 0, "bad_align");

      // Counter bank never answers.
      no_ack = 1'b1;
      axi_write(64'h040, 64'h7, 8'hFF, 0);
      get_b(SLVERR, 0, "to_wr");
      check("to_wr_en_low", 64'(counter_write_enable), 64'd0);
      axi_read(64'h040);
      get_r('1, SLVERR, 0, "to_rd");
      check("to_rd_en_low", 64'(counter_read_enable), 64'd0);
      no_ack = 1'b0;
      axi_read(64'h008);
      get_r(64'hDEAD_BEEF_0000_0001, OKAY, 0, "after_to");

      // Responses held while the master stalls.
      axi_write(64'h048, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
      get_b(OKAY, 10, "hold_b");
      axi_read(64'h048);
      get_r(64'h0123_4567_89AB_CDEF, OKAY, 10, "hold_r");

      // Reset during a pending read.
      no_ack = 1'b1;
      axi_read(64'h008);
      n = 0;
      while (!counter_read_enable && n < 50) begin @(posedge noc_clk); #1; n++; end
      check("mid_rd_en_seen", 64'(counter_read_enable), 64'd1);
      @(posedge noc_clk); #2;
      rst = 1'b0;
      #1;
      check("mid_rst_rd_en", 64'(counter_read_enable), 64'd0);
      check("mid_rst_arready", 64'(s_axi_arready), 64'd0);
      check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      check("mid_rst_cr_addr", 64'(counter_read_address), 64'd0);
      @(posedge noc_clk); #1;
      rst = 1'b1;
      no_ack = 1'b0;
      repeat (2) @(posedge noc_clk);
      #1;
      check("mid_rst_no_rvalid", 64'(s_axi_rvalid), 64'd0);
      axi_read(64'h008);
      get_r(64'hDEAD_BEEF_0000_0001, OKAY, 0, "after_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
